// File: rtl/serial_loader_pkg.sv
// Shared types for the serial word loader: FSM state encoding and counter sizing.
package serial_loader_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOAD} state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

   // Bit counter width for a given word width.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_word_loader.sv
// Assembles a framed MSB-first serial stream into a word, checks optional even
// parity, and presents the word with a one-cycle Load_en for the enable register.
module serial_word_loader
   import serial_loader_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Ser_in,
   input  logic             Ser_valid,
   output logic [WIDTH-1:0] Data_out,
   output logic             Load_en,
   output logic             Busy,
   output logic             Parity_err
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             clr, shift, take, perr_nxt;
   logic [WIDTH-1:0] shift_word, word_in;

   assign shift_word = {shreg[WIDTH-2:0], Ser_in};
   // Without parity the final data bit is still in flight, so load the shifted value.
   assign word_in    = (state == PARITY) ? shreg : shift_word;

   always_ff @(posedge Clock) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      shift     = 1'b0;
      take      = 1'b0;
      perr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               clr       = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (Start) begin
               clr = 1'b1;
            end else if (Ser_valid) begin
               shift = 1'b1;
               if (cnt == LAST) begin
                  if (PARITY_EN) begin
                     state_nxt = PARITY;
                  end else begin
                     take      = 1'b1;
                     state_nxt = LOAD;
                  end
               end
            end
         end
         PARITY: begin
            if (Start) begin
               clr       = 1'b1;
               state_nxt = SHIFT;
            end else if (Ser_valid) begin
               if (Ser_in == ^shreg) begin
                  take      = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  perr_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         LOAD: begin
            state_nxt = IDLE;
            if (Start) begin
               clr       = 1'b1;
               state_nxt = SHIFT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         shreg      <= '0;
         cnt        <= '0;
         Data_out   <= '0;
         Parity_err <= 1'b0;
      end else begin
         Parity_err <= perr_nxt;
         if (clr) begin
            shreg <= '0;
            cnt   <= '0;
         end else if (shift) begin
            shreg <= shift_word;
            cnt   <= cnt + CW'(1);
         end
         if (take) Data_out <= word_in;
      end
   end

   assign Load_en = (state == LOAD);
   assign Busy    = (state == SHIFT) || (state == PARITY);

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench: a parity instance and a no-parity instance, expected words
// queued at drive time and compared whenever Load_en is observed.
module tb_serial_word_loader;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        start_p, ser_p, vld_p;
   logic        start_n, ser_n, vld_n;
   logic [31:0] dout_p, dout_n;
   logic        le_p, le_n, busy_p, busy_n, perr_p, perr_n;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] q_p[$];
   logic [31:0] q_n[$];
   int          loads_p = 0, loads_n = 0, perrs_p = 0;
   logic        le_prev_p = 0, pe_prev_p = 0, le_prev_n = 0;
   bit          mon_on = 0;

   always #5 Clock = ~Clock;

   serial_word_loader #(.WIDTH(32), .PARITY_EN(1'b1)) dut (
      .Clock(Clock), .Reset(Reset), .Start(start_p), .Ser_in(ser_p), .Ser_valid(vld_p),
      .Data_out(dout_p), .Load_en(le_p), .Busy(busy_p), .Parity_err(perr_p));

   serial_word_loader #(.WIDTH(32), .PARITY_EN(1'b0)) dut_np (
      .Clock(Clock), .Reset(Reset), .Start(start_n), .Ser_in(ser_n), .Ser_valid(vld_n),
      .Data_out(dout_n), .Load_en(le_n), .Busy(busy_n), .Parity_err(perr_n));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic put(input int which, input bit st, input bit v, input bit b);
      if (which == 0) begin start_p = st; vld_p = v; ser_p = b; end
      else            begin start_n = st; vld_n = v; ser_n = b; end
   endtask

   // Word bits MSB first, with optional idle cycles between bits.
   task automatic send_word(input int which, input logic [31:0] w, input int gap);
      for (int i = 31; i >= 0; i--) begin
         if (i != 31) begin
            for (int g = 0; g < gap; g++) begin
               put(which, 0, 0, 0);
               tick();
            end
         end
         put(which, 0, 1, w[i]);
         tick();
      end
      put(which, 0, 0, 0);
   endtask

   task automatic send_start(input int which);
      put(which, 1, 0, 0);
      tick();
      put(which, 0, 0, 0);
   endtask

   // Parity bit; leaves the DUT in LOAD (good) or IDLE (bad) on return.
   task automatic send_parity(input logic [31:0] w, input bit good);
      put(0, 0, 1, good ? ^w : ~^w);
      if (good) q_p.push_back(w);
      tick();
      put(0, 0, 0, 0);
   endtask

   always @(negedge Clock) begin
      if (mon_on) begin
         if (le_p) begin
            loads_p++;
            if (q_p.size() == 0) chk("unexpected_load_p", {31'd0, le_p}, 32'd0);
            else                 chk("load_data_p", dout_p, q_p.pop_front());
         end
         if (le_n) begin
            loads_n++;
            if (q_n.size() == 0) chk("unexpected_load_n", {31'd0, le_n}, 32'd0);
            else                 chk("load_data_n", dout_n, q_n.pop_front());
         end
         if (perr_p) perrs_p++;
         if (le_p & perr_p)      chk("le_perr_overlap", {31'd0, le_p & perr_p}, 32'd0);
         if (le_p & le_prev_p)   chk("le_pulse_width_p", {31'd0, le_p}, 32'd0);
         if (perr_p & pe_prev_p) chk("perr_pulse_width", {31'd0, perr_p}, 32'd0);
         if (le_n & le_prev_n)   chk("le_pulse_width_n", {31'd0, le_n}, 32'd0);
         if (perr_n)             chk("perr_np", {31'd0, perr_n}, 32'd0);
         le_prev_p = le_p;
         pe_prev_p = perr_p;
         le_prev_n = le_n;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      Reset = 1'b0;
      put(0, 0, 0, 0);
      put(1, 0, 0, 0);
      tick();
      tick();
      chk("rst_data", dout_p, 32'd0);
      chk("rst_flags", {28'd0, le_p, busy_p, perr_p, busy_n}, 32'd0);
      chk("rst_data_np", dout_n, 32'd0);
      Reset = 1'b1;
      mon_on = 1;
      tick();
      chk("idle_busy", {31'd0, busy_p}, 32'd0);

      // Good frame
      w = 32'hA5A5_0F0F;
      send_start(0);
      chk("busy_after_start", {31'd0, busy_p}, 32'd1);
      send_word(0, w, 0);
      chk("busy_in_parity", {31'd0, busy_p}, 32'd1);
      send_parity(w, 1);
      chk("a5_data", dout_p, w);
      chk("a5_le_busy", {30'd0, le_p, busy_p}, 32'b10);
      tick();
      chk("a5_after_load", {30'd0, le_p, busy_p}, 32'b00);

      // Same frame, wrong parity
      send_start(0);
      send_word(0, w, 0);
      send_parity(w, 0);
      chk("perr_pulse", {30'd0, perr_p, le_p}, 32'b10);
      chk("perr_hold_data", dout_p, 32'hA5A5_0F0F);
      tick();
      chk("perr_clear", {30'd0, perr_p, busy_p}, 32'b00);

      // Different word with wrong parity must not disturb Data_out
      send_start(0);
      send_word(0, 32'h1234_5678, 0);
      send_parity(32'h1234_5678, 0);
      chk("perr2_hold_data", dout_p, 32'hA5A5_0F0F);
      tick();

      // Sparse Ser_valid
      w = 32'h0000_0010;
      send_start(0);
      send_word(0, w, 1);
      put(0, 0, 0, 0);
      tick();
      chk("gap_wait_parity", {31'd0, busy_p}, 32'd1);
      send_parity(w, 1);
      chk("gap_data", dout_p, w);
      tick();

      // Restart after 10 bits
      send_start(0);
      for (int i = 0; i < 10; i++) begin
         put(0, 0, 1, 1'(i & 1));
         tick();
      end
      w = 32'h0000_0006;
      send_start(0);
      send_word(0, w, 0);
      send_parity(w, 1);
      chk("restart_data", dout_p, w);
      tick();

      // Reset mid-frame
      send_start(0);
      for (int i = 0; i < 20; i++) begin
         put(0, 0, 1, 1);
         tick();
      end
      put(0, 0, 0, 0);
      Reset = 1'b0;
      tick();
      chk("midrst_busy", {31'd0, busy_p}, 32'd0);
      chk("midrst_data", dout_p, 32'd0);
      Reset = 1'b1;
      w = 32'h0000_0008;
      send_start(0);
      send_word(0, w, 0);
      send_parity(w, 1);
      chk("postrst_data", dout_p, w);
      tick();

      // No-parity instance, back-to-back frames
      w = 32'hFFFF_FFFF;
      send_start(1);
      send_word(1, w, 0);
      q_n.push_back(w);
      chk("np_le", {31'd0, le_n}, 32'd1);
      chk("np_data", dout_n, w);
      // Start during LOAD with a simultaneous valid bit that must be dropped
      put(1, 1, 1, 1);
      tick();
      chk("np_b2b_busy", {30'd0, busy_n, le_n}, 32'b10);
      w = 32'h1234_5678;
      send_word(1, w, 0);
      q_n.push_back(w);
      chk("np_b2b_data", dout_n, w);
      tick();
      tick();

      chk("q_p_empty", q_p.size(), 32'd0);
      chk("q_n_empty", q_n.size(), 32'd0);
      chk("loads_p", loads_p, 32'd4);
      chk("loads_n", loads_n, 32'd2);
      chk("perrs_p", perrs_p, 32'd2);
      mon_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_word_loader.md
# serial_word_loader

Upstream feeder for the 32-bit enable register. It assembles a framed serial bit stream into a parallel word, checks an optional even-parity bit, and presents the word on `Data_out` with a one-cycle `Load_en` pulse. Its outputs connect directly to the register's `Data_in` and `En`. Corrupted or aborted frames never produce a load.

## Interface
Parameters:
- `WIDTH`, 32: word width in bits. Must be ≥2.
- `PARITY_EN`, 1: 1 means one even-parity bit follows the data; 0 means no parity bit.

Ports:
- `Clock`  in  1  single clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `Clock`; overrides all other inputs.
- `Start`  in  1  frame start strobe; the cycle in which it is high carries no data bit.
- `Ser_in`  in  1  serial data bit, MSB first; qualified by `Ser_valid`.
- `Ser_valid`  in  1  `Ser_in` is a valid bit this cycle.
- `Data_out`  out  WIDTH  last successfully received word; connects to the register's `Data_in`.
- `Load_en`  out  1  one-cycle pulse when `Data_out` is new; connects to the register's `En`.
- `Busy`  out  1  a frame is in progress (state SHIFT or PARITY).
- `Parity_err`  out  1  one-cycle pulse on a parity mismatch.

## Operation
States: IDLE, SHIFT, PARITY, LOAD. An internal shift register `shreg` holds WIDTH bits; a bit counter `cnt` is `$clog2(WIDTH)` bits wide.
- IDLE:
  - `Start`=1: clear `shreg` and `cnt`, go to SHIFT.
  - `Ser_valid` is ignored.
- SHIFT:
  - `Start`=1 takes priority: clear `shreg` and `cnt`, stay in SHIFT (restart). The partial word is discarded.
  - Otherwise, on `Ser_valid`=1: `shreg <= {shreg[WIDTH-2:0], Ser_in}` and `cnt` increments.
  - When `Ser_valid`=1 and `cnt`==WIDTH-1 (the last data bit), go to PARITY if `PARITY_EN`=1.
  - If `PARITY_EN`=0, go to LOAD instead and update `Data_out` with the completed word at that edge.
  - `Ser_valid`=0: hold state.
- PARITY:
  - `Start`=1: restart as in SHIFT.
  - On `Ser_valid`=1 with `Ser_in` == `^shreg`: `Data_out <= shreg`, go to LOAD.
  - On `Ser_valid`=1 with a mismatch: `Data_out` is unchanged, `Parity_err` is high for the next cycle, go to IDLE.
- LOAD:
  - `Load_en`=1 for exactly this one cycle, decoded from the state.
  - Next state is IDLE. If `Start`=1 in this cycle, next state is SHIFT with `shreg` and `cnt` cleared; the load still completes.
  - `Ser_valid` is ignored.
- `Busy` = (state==SHIFT) or (state==PARITY).
- No other path modifies `Data_out`; it holds its value indefinitely between loads.

## Timing
- Reset values (`Reset`=0 at a rising edge): state IDLE, `Data_out`=0, `Load_en`=0, `Busy`=0, `Parity_err`=0, `cnt`=0, `shreg`=0. All take effect at that edge, including when reset arrives mid-frame.
- Latency, measured from the edge that samples the final bit (the parity bit, or the last data bit when `PARITY_EN`=0):
  - `Data_out` is new after that edge.
  - `Load_en` is high during the following cycle.
  - The downstream register captures the word on the next edge, so the total is 2 edges.
- Minimum frame length: 1 `Start` cycle + WIDTH + `PARITY_EN` valid cycles + 1 LOAD cycle. Back-to-back frames are possible by asserting `Start` during LOAD.
- `Load_en` and `Parity_err` are never high together, and neither is ever high for more than one cycle.
- `Start` and `Ser_valid` both high in the same cycle: `Start` wins and the bit is dropped.

## Structure
- Shared package `serial_loader_pkg` contains:
  - the state enum (IDLE, SHIFT, PARITY, LOAD);
  - the `cnt` width localparam.
- No sub-module is needed. The block is a single module: one FSM, the shift register, the counter, and the `Data_out` register.

## Test plan
- `Start`, then 32'hA5A5_0F0F MSB-first with parity bit 0 (16 ones) -> `Data_out`=32'hA5A5_0F0F after the parity edge, `Load_en` high for one cycle, `Busy` low from the LOAD cycle onward.
- The same frame with parity bit 1 -> `Parity_err` pulses once, `Data_out` keeps its previous value, no `Load_en`.
- 32'h0000_0010 with parity 1, `Ser_valid` high only every other cycle -> correct load; `cnt` holds during the gaps.
- `Start`, 10 bits, `Start` again, then 32'h0000_0006 with parity 0 -> `Data_out`=32'h0000_0006, exactly one `Load_en` pulse.
- `Reset`=0 after 20 bits of a frame -> at the next edge `Busy`=0 and `Data_out`=0; a following full frame 32'h0000_0008 with parity 1 loads normally.
- `PARITY_EN`=0, 32'hFFFF_FFFF -> `Load_en` in the cycle after the 32nd bit edge; `Start` asserted during LOAD begins the next frame with no idle cycle.
